entry_loader: RTL
=================

ENTRY_LOADER -- requirements
Module: entry_loader

Interface
REQ-001 The block SHALL have parameter SIZE, default 16, value range of each entry (value field width clog2(SIZE)).
REQ-002 The block SHALL have parameter K, default 8, number of entries per frame (index field width clog2(K)).
REQ-003 The block SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 The block SHALL have port start  input  1  begins a new frame, honoured in IDLE only.
REQ-006 The block SHALL have port in_valid  input  1  in_value is valid this cycle.
REQ-007 The block SHALL have port in_value  input  clog2(SIZE)  value of the next entry.
REQ-008 The block SHALL have port in_ready  output  1  entry is accepted when in_valid and in_ready are both 1.
REQ-009 The block SHALL have port out_valid  output  1  packed frame is complete and stable.
REQ-010 The block SHALL have port out_ack  input  1  downstream selector array has consumed the frame.
REQ-011 The block SHALL have port packed_inputs  output  (clog2(K)+clog2(SIZE))*K  frame feeding the selector array; entry i occupies bits [(i+1)*W-1 -: W], W = clog2(K)+clog2(SIZE); within an entry, index in the upper clog2(K) bits, value in the lower clog2(SIZE) bits.
REQ-012 The block SHALL have port count  output  clog2(K)+1  entries accepted in the current frame.
REQ-013 The block SHALL have port dup_err  output  1  at least two entries in the current frame share a value.

Function
REQ-014 The block SHALL implement states IDLE, LOAD, HOLD; in_ready = 1 only in LOAD; out_valid = 1 only in HOLD; both are registered-state decodes, no combinational path from inputs.
REQ-015 In IDLE, start = 1 SHALL move to LOAD next cycle and clear count, dup_err, all entries and the internal SIZE-bit seen-value bitmap in that same edge.
REQ-016 In LOAD, each accepted entry SHALL be written to slot count as {count[clog2(K)-1:0], in_value}, count incremented by 1, bitmap bit in_value set.
REQ-017 If the bitmap bit for an accepted in_value is already set, dup_err SHALL be set at that edge and remain set until the next honoured start or reset.
REQ-018 Acceptance of the K-th entry SHALL move to HOLD; out_valid rises the cycle after that acceptance (latency 1 cycle), count = K.
REQ-019 In HOLD, packed_inputs, count and dup_err SHALL remain stable; out_ack = 1 SHALL move to IDLE next cycle.
REQ-020 packed_inputs SHALL retain the last frame in IDLE until the next honoured start clears it.
REQ-021 start SHALL be ignored in LOAD and HOLD; start and out_ack together in HOLD: ack taken, start ignored.
REQ-022 out_ack outside HOLD SHALL be ignored; in_valid outside LOAD SHALL be ignored (no write, no count change).
REQ-023 in_valid gaps in LOAD SHALL stall without timeout; no state change until next acceptance.

Reset
REQ-024 rst = 1 SHALL immediately force IDLE, in_ready = 0, out_valid = 0, dup_err = 0, count = 0, packed_inputs = 0, bitmap = 0, regardless of state (including mid-LOAD and HOLD).
REQ-025 After rst deasserts, the block SHALL require a start before accepting any entry.

Verification
REQ-026 Reset, start, 8 back-to-back values 3,7,0,15,1,2,9,4 -> out_valid rises cycle after 8th, entry 0 = {0,3}, entry 3 = {3,15}, entry 7 = {7,4}, dup_err = 0, count = 8.
REQ-027 Frame with values 5,5,1,2,3,4,6,7 -> dup_err = 1 from the edge accepting the second 5, held through HOLD; next start clears it.
REQ-028 in_valid toggling every other cycle -> 8 entries take 15 cycles, order and indices identical to back-to-back case.
REQ-029 rst asserted after 4 entries accepted -> same cycle: in_ready = 0, count = 0, packed_inputs = 0; in_valid without start afterwards accepts nothing.
REQ-030 In HOLD, start and out_ack together -> IDLE next cycle, in_ready stays 0, packed_inputs unchanged; start in the following cycle -> LOAD, entries cleared.
REQ-031 out_ack pulsed during LOAD and in_valid during HOLD -> no effect on state, count, or packed_inputs.

Source files
------------

// File: rtl/entry_loader.sv
// entry_loader: collects K (index, value) entries into one packed frame for a
// downstream selector array.
//
// Ports
//   clk, rst       rising-edge clock, asynchronous active-high reset
//   start          begins a new frame (taken in IDLE only)
//   in_valid/ready entry handshake; in_ready is high only while loading
//   in_value       value of the next entry
//   out_valid      frame complete and stable (HOLD)
//   out_ack        downstream consumed the frame (taken in HOLD only)
//   packed_inputs  K entries; entry i = {i, value} at [(i+1)*W-1 -: W]
//   count          entries accepted in the current frame
//   dup_err        two or more entries of the current frame share a value

// One frame slot. It is cleared when a frame starts and written once
// while the frame loads.
module entry_slot #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         we,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            dout <= '0;
        else if (clr)
            dout <= '0;
        else if (we)
            dout <= din;
    end
endmodule

module entry_loader #(
    parameter int SIZE = 16,
    parameter int K    = 8
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         start,
    input  logic                                         in_valid,
    input  logic [$clog2(SIZE)-1:0]                      in_value,
    output logic                                         in_ready,
    output logic                                         out_valid,
    input  logic                                         out_ack,
    output logic [($clog2(K)+$clog2(SIZE))*K-1:0]        packed_inputs,
    output logic [$clog2(K):0]                           count,
    output logic                                         dup_err
);
    localparam int VW = $clog2(SIZE);
    localparam int IW = $clog2(K);
    localparam int W  = IW + VW;
    localparam int CW = IW + 1;

    typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;

    state_t          state;
    logic [SIZE-1:0] seen;   // values already present in this frame

    // in_ready is a registered decode of LOAD, so acc never depends
    // combinationally on anything but in_valid.
    logic acc, clr, last;
    assign acc  = in_valid & in_ready;
    assign clr  = (state == IDLE) & start;
    assign last = (count == CW'(K - 1));

    // Slot index is the low bits of count: slot count gets {count, value}.
    genvar i;
    generate
        for (i = 0; i < K; i++) begin : g_slot
            entry_slot #(.W(W)) u_slot (
                .clk  (clk),
                .rst  (rst),
                .clr  (clr),
                .we   (acc && (count[IW-1:0] == IW'(i))),
                .din  ({count[IW-1:0], in_value}),
                .dout (packed_inputs[(i+1)*W-1 -: W])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            count     <= '0;
            dup_err   <= 1'b0;
            seen      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // Last frame stays visible until the next start clears it.
                    if (start) begin
                        state    <= LOAD;
                        in_ready <= 1'b1;
                        count    <= '0;
                        dup_err  <= 1'b0;
                        seen     <= '0;
                    end
                end
                LOAD: begin
                    if (acc) begin
                        seen[in_value] <= 1'b1;
                        count          <= count + CW'(1);
                        if (seen[in_value])
                            dup_err <= 1'b1;
                        if (last) begin
                            state     <= HOLD;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ack) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule
